// File: rtl/sha256_stream_core.sv
// sha256_stream_core
// SHA-256 / SHA-224 compression engine fed with pre-padded 512-bit blocks,
// one 32-bit big-endian word per valid/ready transfer. Blocks are chained
// until one arrives flagged as last, then the digest is presented in parallel.
//
// Parameters:
//   ROUNDS_PER_CYCLE  compression rounds per clock (1, 2 or 4)
//   SHA224_EN         1 allows mode_in to select SHA-224; 0 forces SHA-256
// Ports:
//   clk_in, rst_in            rising-edge clock, async active-low reset
//   start_in, mode_in         begin a message (IDLE only); mode 1 = SHA-224
//   abort_in                  return to IDLE from any state
//   blk_valid_in/ready_out    word handshake; ready only while loading
//   blk_data_in, blk_last_in  message word; last flag read on the 16th word
//   busy_out, done_out        not idle / one-cycle digest-valid pulse
//   digest_out                H0 in [255:224] .. H7 in [31:0]
module sha256_stream_core #(
    parameter int unsigned ROUNDS_PER_CYCLE = 1,
    parameter bit          SHA224_EN        = 1'b1
) (
    input  logic         clk_in,
    input  logic         rst_in,
    input  logic         start_in,
    input  logic         mode_in,
    input  logic         abort_in,
    input  logic         blk_valid_in,
    output logic         blk_ready_out,
    input  logic [31:0]  blk_data_in,
    input  logic         blk_last_in,
    output logic         busy_out,
    output logic         done_out,
    output logic [255:0] digest_out
);

    generate
        if (!(ROUNDS_PER_CYCLE == 1 || ROUNDS_PER_CYCLE == 2 || ROUNDS_PER_CYCLE == 4)) begin : g_bad_rounds
            $error("sha256_stream_core: ROUNDS_PER_CYCLE must be 1, 2 or 4");
        end
    endgenerate

    localparam logic [5:0] LAST_RND = 6'(64 - ROUNDS_PER_CYCLE);

    localparam logic [31:0] IV_256 [8] = '{
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
    localparam logic [31:0] IV_224 [8] = '{
        32'hc1059ed8, 32'h367cd507, 32'h3070dd17, 32'hf70e5939,
        32'hffc00b31, 32'h68581511, 32'h64f98fa7, 32'hbefa4fa4};
    localparam logic [31:0] K_TAB [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_ROUND = 3'd2,
        ST_FINAL = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] big_sigma0(input logic [31:0] x);
        return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
    endfunction

    function automatic logic [31:0] big_sigma1(input logic [31:0] x);
        return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
    endfunction

    function automatic logic [31:0] small_sigma0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] small_sigma1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    function automatic logic [31:0] ch(input logic [31:0] e, input logic [31:0] f, input logic [31:0] g);
        return (e & f) ^ (~e & g);
    endfunction

    function automatic logic [31:0] maj(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
        return (a & b) ^ (a & c) ^ (b & c);
    endfunction

    state_t         state_q, state_d;
    logic [31:0]    h_q [8];
    logic [31:0]    h_d [8];
    logic [31:0]    v_q [8];     // working variables a..h
    logic [31:0]    v_d [8];
    logic [31:0]    w_q [16];    // rolling schedule window, w_q[0] = W[t]
    logic [31:0]    w_d [16];
    logic [3:0]     cnt_q, cnt_d;
    logic [5:0]     rnd_q, rnd_d;
    logic           last_q, last_d;
    logic           mode_q, mode_d;
    logic           ready_q, ready_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic [255:0]   digest_q, digest_d;

    logic [31:0]    rv_s [8];
    logic [31:0]    rw_s [16];
    logic [31:0]    t1_s, t2_s, wn_s;
    logic [5:0]     kidx_s;
    logic           xfer_s;

    assign blk_ready_out = ready_q;
    assign busy_out      = busy_q;
    assign done_out      = done_q;
    assign digest_out    = digest_q;

    // ready_q is high exactly in LOAD, so this is the accepted-word strobe
    assign xfer_s = blk_valid_in & ready_q;

    // Round datapath: ROUNDS_PER_CYCLE chained rounds. Each round also
    // produces W[t+16] from the window and shifts it in, so the window
    // always starts at the word the next round consumes.
    always_comb begin
        rv_s   = v_q;
        rw_s   = w_q;
        t1_s   = 32'h0;
        t2_s   = 32'h0;
        wn_s   = 32'h0;
        kidx_s = rnd_q;
        for (int r = 0; r < int'(ROUNDS_PER_CYCLE); r++) begin
            kidx_s = rnd_q + 6'(r);
            t1_s = rv_s[7] + big_sigma1(rv_s[4]) + ch(rv_s[4], rv_s[5], rv_s[6]) + K_TAB[kidx_s] + rw_s[0];
            t2_s = big_sigma0(rv_s[0]) + maj(rv_s[0], rv_s[1], rv_s[2]);
            wn_s = small_sigma1(rw_s[14]) + rw_s[9] + small_sigma0(rw_s[1]) + rw_s[0];
            rv_s[7] = rv_s[6];
            rv_s[6] = rv_s[5];
            rv_s[5] = rv_s[4];
            rv_s[4] = rv_s[3] + t1_s;
            rv_s[3] = rv_s[2];
            rv_s[2] = rv_s[1];
            rv_s[1] = rv_s[0];
            rv_s[0] = t1_s + t2_s;
            for (int j = 0; j < 15; j++) begin
                rw_s[j] = rw_s[j + 1];
            end
            rw_s[15] = wn_s;
        end
    end

    // Next-state and datapath register updates; outputs follow the next state
    always_comb begin
        state_d  = state_q;
        h_d      = h_q;
        v_d      = v_q;
        w_d      = w_q;
        cnt_d    = cnt_q;
        rnd_d    = rnd_q;
        last_d   = last_q;
        mode_d   = mode_q;
        digest_d = digest_q;

        if (abort_in) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_in) begin
                        mode_d  = SHA224_EN & mode_in;
                        h_d     = (SHA224_EN & mode_in) ? IV_224 : IV_256;
                        cnt_d   = 4'd0;
                        state_d = ST_LOAD;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_LOAD: begin
                    if (xfer_s) begin
                        w_d[cnt_q] = blk_data_in;
                        cnt_d      = cnt_q + 4'd1;
                        if (cnt_q == 4'd15) begin
                            last_d  = blk_last_in;
                            v_d     = h_q;
                            rnd_d   = 6'd0;
                            state_d = ST_ROUND;
                        end else begin
                            state_d = ST_LOAD;
                        end
                    end else begin
                        state_d = ST_LOAD;
                    end
                end
                ST_ROUND: begin
                    v_d   = rv_s;
                    w_d   = rw_s;
                    rnd_d = rnd_q + 6'(ROUNDS_PER_CYCLE);
                    if (rnd_q == LAST_RND) begin
                        state_d = ST_FINAL;
                    end else begin
                        state_d = ST_ROUND;
                    end
                end
                ST_FINAL: begin
                    for (int i = 0; i < 8; i++) begin
                        h_d[i] = h_q[i] + v_q[i];
                    end
                    cnt_d   = 4'd0;
                    state_d = last_q ? ST_DONE : ST_LOAD;
                end
                ST_DONE: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        // DONE is only entered from FINAL, so h_d already holds the result
        if (state_d == ST_DONE) begin
            for (int i = 0; i < 8; i++) begin
                digest_d[255 - 32 * i -: 32] = h_d[i];
            end
            if (mode_q) begin
                digest_d[31:0] = 32'h0;
            end else begin
                digest_d[31:0] = h_d[7];
            end
        end else begin
            digest_d = digest_q;
        end

        ready_d = (state_d == ST_LOAD);
        busy_d  = (state_d != ST_IDLE);
        done_d  = (state_d == ST_DONE);
    end

    // State and datapath registers, cleared by the asynchronous reset
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q  <= ST_IDLE;
            for (int i = 0; i < 8; i++) begin
                h_q[i] <= 32'h0;
                v_q[i] <= 32'h0;
            end
            for (int i = 0; i < 16; i++) begin
                w_q[i] <= 32'h0;
            end
            cnt_q    <= 4'd0;
            rnd_q    <= 6'd0;
            last_q   <= 1'b0;
            mode_q   <= 1'b0;
            ready_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            digest_q <= 256'h0;
        end else begin
            state_q  <= state_d;
            h_q      <= h_d;
            v_q      <= v_d;
            w_q      <= w_d;
            cnt_q    <= cnt_d;
            rnd_q    <= rnd_d;
            last_q   <= last_d;
            mode_q   <= mode_d;
            ready_q  <= ready_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            digest_q <= digest_d;
        end
    end

endmodule
